// File: rtl/calc_pkg.sv
// Shared calculator datapath definitions used by suma, conv_bcd and the
// 7-segment display driver.
//   CALC_WIDTH  : width of the signed adder result word
//   CALC_DIGITS : number of BCD digits shown on the display
//   CALC_MAX    : largest magnitude the display can show
//   BCD_BLANK   : digit code the display driver renders as an unlit digit
//   bcd_state_t : state type of the binary-to-BCD converter FSM
package calc_pkg;

  localparam int         CALC_WIDTH  = 28;
  localparam int         CALC_DIGITS = 8;
  localparam int         CALC_MAX    = 99_999_999;
  localparam logic [3:0] BCD_BLANK   = 4'hF;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } bcd_state_t;

endpackage

// File: rtl/bcd_add3.sv
// Single-digit correction cell of the double-dabble converter: a digit of
// 5 or more is pre-corrected by +3 so that the following left shift carries
// correctly into the next decimal digit.
// Ports:
//   d : BCD digit before correction
//   q : corrected digit
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_comb begin
    q = (d >= 4'd5) ? d + 4'd3 : d;
  end

endmodule

// File: rtl/conv_bcd.sv
// Sequential binary-to-BCD converter behind the suma adder. A rising edge of
// valid_in (while idle) captures the signed sum, its sign and the overflow
// flag; the magnitude is then converted one bit per clock by shift-add-3.
// The result registers load once, together with a one-cycle valid_out pulse,
// WIDTH cycles after acceptance, and hold until the next result.
// Optional build macro:
//   CONV_BCD_BLANK_EN : leading zero digits (never the lowest) become 4'hF.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   valid_in   : sum valid from suma; only its rising edge starts a conversion
//   d_in       : signed two's-complement sum
//   ovrflow_in : adder overflow, sampled with d_in
//   busy       : conversion in progress
//   valid_out  : one-cycle pulse when bcd_out/neg/err are updated
//   bcd_out    : BCD magnitude, most significant digit in the top nibble
//   neg        : accepted value was negative (forced low on error)
//   err        : overflow or magnitude beyond the display range
module conv_bcd
  import calc_pkg::*;
#(
  parameter int WIDTH  = CALC_WIDTH,
  parameter int DIGITS = CALC_DIGITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_in,
  input  logic [WIDTH-1:0]    d_in,
  input  logic                ovrflow_in,
  output logic                busy,
  output logic                valid_out,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                neg,
  output logic                err
);

  localparam int              CW    = $clog2(WIDTH + 1);
  localparam int              BW    = 4 * DIGITS;
  localparam logic [CW-1:0]   LAST  = CW'(WIDTH - 1);
  localparam logic [63:0]     MAX64 = 64'(CALC_MAX);

  bcd_state_t        state, state_nxt;
  logic              vin_q;
  logic [CW-1:0]     cnt;
  logic              accept, last;
  logic [WIDTH-1:0]  mag_abs;
  logic [WIDTH-1:0]  mag_p0;
  logic [BW-1:0]     bcd_p0, bcd_adj, bcd_shf, bcd_res;
  logic              neg_p0, err_p0;

  // Magnitude kept at WIDTH bits unsigned, so the most negative value maps
  // to 2^(WIDTH-1) instead of wrapping back to itself.
  function automatic logic [WIDTH-1:0] abs_mag(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

`ifdef CONV_BCD_BLANK_EN
  function automatic logic [BW-1:0] blank_lz(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    logic          lead;
    r    = b;
    lead = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (lead && (b[4*i +: 4] == 4'd0)) r[4*i +: 4] = BCD_BLANK;
      else                               lead = 1'b0;
    end
    return r;
  endfunction
`endif

  always_comb begin
    mag_abs = abs_mag($signed(d_in));
  end

  // Shift-add-3 datapath: correct every digit, then shift the next
  // magnitude bit in at the bottom.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d (bcd_p0[4*g +: 4]),
      .q (bcd_adj[4*g +: 4])
    );
  end

  always_comb begin
    bcd_shf = {bcd_adj[BW-2:0], mag_p0[WIDTH-1]};
`ifdef CONV_BCD_BLANK_EN
    bcd_res = blank_lz(bcd_shf);
`else
    bcd_res = bcd_shf;
`endif
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (valid_in && !vin_q) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      vin_q     <= 1'b0;
      cnt       <= '0;
      valid_out <= 1'b0;
      bcd_out   <= '0;
      neg       <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      vin_q     <= valid_in;
      valid_out <= last;
      if (accept)              cnt <= '0;
      else if (state == SHIFT) cnt <= cnt + CW'(1);
      if (last) begin
        bcd_out <= err_p0 ? {DIGITS{BCD_BLANK}} : bcd_res;
        neg     <= neg_p0 & ~err_p0;
        err     <= err_p0;
      end
    end
  end

  // ---- stage p0: capture on acceptance, shift while converting ----
  always_ff @(posedge clk) begin
    if (accept) begin
      mag_p0 <= mag_abs;
      bcd_p0 <= '0;
      neg_p0 <= d_in[WIDTH-1];
      err_p0 <= ovrflow_in || (64'(mag_abs) > MAX64);
    end else if (state == SHIFT) begin
      mag_p0 <= {mag_p0[WIDTH-2:0], 1'b0};
      bcd_p0 <= bcd_shf;
    end
  end

endmodule

// File: tb/tb_conv_bcd.sv
// Self-checking bench for conv_bcd: reset behaviour, a table of directed
// values including range boundaries, overlapping requests, acceptance in the
// result cycle, reset during a conversion, and random values checked against
// an arithmetic reference model.
module tb_conv_bcd;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic        ovrflow_in = 1'b0;
  logic [27:0] d_in = '0;
  logic        busy, valid_out, neg, err;
  logic [31:0] bcd_out;

  int total = 0;
  int bad   = 0;

  conv_bcd dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .d_in       (d_in),
    .ovrflow_in (ovrflow_in),
    .busy       (busy),
    .valid_out  (valid_out),
    .bcd_out    (bcd_out),
    .neg        (neg),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [27:0] d;
    logic        ovf;
    int          hold;
    logic [31:0] eb;
    logic        en;
    logic        ee;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: decimal digits from plain division, range test on the true
  // magnitude, blanking decided by the number of significant digits.
  function automatic void model(input logic [27:0] d, input logic ovf,
                                output logic [31:0] b, output logic n, output logic e);
    logic signed [27:0] ds;
    longint v, m, p;
    ds = d;
    v  = longint'(ds);
    m  = (v < 0) ? -v : v;
    e  = ovf || (m > 64'd99999999);
    b  = '0;
    n  = 1'b0;
    if (e) begin
      b = 32'hFFFF_FFFF;
    end else begin
      n = (v < 0);
      p = 1;
      for (int i = 0; i < 8; i++) begin
        b[4*i +: 4] = 4'((m / p) % 10);
`ifdef CONV_BCD_BLANK_EN
        if (i > 0 && m < p) b[4*i +: 4] = 4'hF;
`endif
        p = p * 10;
      end
    end
  endfunction

  // Called at a falling edge; presents a request, returns one cycle later.
  task automatic start(input logic [27:0] d, input logic ovf, input int hold);
    d_in       = d;
    ovrflow_in = ovf;
    valid_in   = 1'b1;
    @(negedge clk);
    check("busy_after_accept", 32'(busy), 32'd1);
    if (hold <= 1) valid_in = 1'b0;
  endtask

  // Waits for valid_out; lat counts clock edges since acceptance.
  task automatic finish_conv(input int hold, output int lat, output logic ok);
    lat = 0;
    ok  = 1'b0;
    while (!ok && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat + 1 >= hold) valid_in = 1'b0;
      if (valid_out) ok = 1'b1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL timeout: got no valid_out want pulse within 40 cycles");
    end
  endtask

  task automatic run_and_check(input string tag, input logic [27:0] d, input logic ovf,
                               input int hold, input logic [31:0] eb, input logic en,
                               input logic ee);
    int   lat;
    logic ok;
    start(d, ovf, hold);
    finish_conv(hold, lat, ok);
    if (ok) begin
      check({tag, "_latency"}, 32'(lat), 32'd28);
      check({tag, "_bcd"}, bcd_out, eb);
      check({tag, "_neg"}, 32'(neg), 32'(en));
      check({tag, "_err"}, 32'(err), 32'(ee));
      check({tag, "_busy_in_vo"}, 32'(busy), 32'd0);
      @(negedge clk);
      check({tag, "_vo_single"}, 32'(valid_out), 32'd0);
      check({tag, "_bcd_hold"}, bcd_out, eb);
    end
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    int pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (valid_out) pulses++;
    end
    check(name, 32'(pulses), 32'd0);
  endtask

  initial begin
    logic [31:0] eb;
    logic        en, ee;
    int          lat;
    logic        ok;

`ifdef CONV_BCD_BLANK_EN
    tbl[0] = '{28'd3946,           1'b0, 3, 32'hFFFF3946, 1'b0, 1'b0};
    tbl[1] = '{28'(-2436),         1'b0, 1, 32'hFFFF2436, 1'b1, 1'b0};
    tbl[2] = '{28'd0,              1'b0, 2, 32'hFFFFFFF0, 1'b0, 1'b0};
`else
    tbl[0] = '{28'd3946,           1'b0, 3, 32'h00003946, 1'b0, 1'b0};
    tbl[1] = '{28'(-2436),         1'b0, 1, 32'h00002436, 1'b1, 1'b0};
    tbl[2] = '{28'd0,              1'b0, 2, 32'h00000000, 1'b0, 1'b0};
`endif
    tbl[3] = '{28'd99999999,       1'b0, 1, 32'h99999999, 1'b0, 1'b0};
    tbl[4] = '{28'd100000020,      1'b0, 2, 32'hFFFFFFFF, 1'b0, 1'b1};
    tbl[5] = '{28'h8000000,        1'b0, 1, 32'hFFFFFFFF, 1'b0, 1'b1};
    tbl[6] = '{28'd5,              1'b1, 1, 32'hFFFFFFFF, 1'b0, 1'b1};
    tbl[7] = '{28'(-99999999),     1'b0, 4, 32'h99999999, 1'b1, 1'b0};

    // Reset held with valid_in toggling: nothing may move.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      valid_in = ~valid_in;
      d_in     = 28'd1234;
      check("reset_outputs", {busy, valid_out, neg, err, 28'd0} | bcd_out, 32'd0);
    end
    valid_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", {busy, valid_out, neg, err, 28'd0} | bcd_out, 32'd0);

    for (int i = 0; i < 8; i++)
      run_and_check($sformatf("vec%0d", i), tbl[i].d, tbl[i].ovf, tbl[i].hold,
                    tbl[i].eb, tbl[i].en, tbl[i].ee);

    // Second rising edge during a conversion is dropped, not queued.
    start(28'd1234, 1'b0, 1);
    repeat (9) @(negedge clk);
    d_in     = 28'd5678;
    valid_in = 1'b1;
    repeat (2) @(negedge clk);
    valid_in = 1'b0;
    finish_conv(0, lat, ok);
    model(28'd1234, 1'b0, eb, en, ee);
    check("overlap_first_result", bcd_out, eb);
    expect_quiet("overlap_no_second_result", 40);

    // Rising edge in the valid_out cycle is accepted.
    start(28'd777, 1'b0, 1);
    finish_conv(1, lat, ok);
    model(28'd777, 1'b0, eb, en, ee);
    check("vo_cycle_first_bcd", bcd_out, eb);
    start(28'd888, 1'b0, 1);
    finish_conv(1, lat, ok);
    model(28'd888, 1'b0, eb, en, ee);
    check("vo_cycle_second_latency", 32'(lat), 32'd28);
    check("vo_cycle_second_bcd", bcd_out, eb);
    @(negedge clk);

    // Reset ten cycles into a conversion aborts it.
    start(28'd5555, 1'b0, 1);
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midreset_outputs", {busy, valid_out, neg, err, 28'd0} | bcd_out, 32'd0);
    repeat (2) @(negedge clk);
    check("midreset_outputs_held", {busy, valid_out, neg, err, 28'd0} | bcd_out, 32'd0);
    rst = 1'b1;
    expect_quiet("midreset_no_result", 40);
    model(28'd412, 1'b0, eb, en, ee);
    run_and_check("after_midreset", 28'd412, 1'b0, 1, eb, en, ee);

    // Random values against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [27:0] d;
      logic        ovf;
      int          sel;
      sel = $urandom_range(0, 3);
      if (sel == 0)      d = 28'($urandom);
      else if (sel == 1) d = 28'($urandom_range(99999990, 100000010));
      else               d = 28'($urandom_range(0, 99999999));
      if ($urandom_range(0, 1) == 1) d = -d;
      ovf = ($urandom_range(0, 7) == 0);
      model(d, ovf, eb, en, ee);
      run_and_check($sformatf("rand%0d", i), d, ovf, $urandom_range(1, 4), eb, en, ee);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
